ps2_keyboard_rx: RTL
====================

Name: ps2_keyboard_rx

Overview:
- Next-generation PS/2 keyboard receiver, clocked from the system clock rather than from PS2_CLK.
- Oversamples PS2_CLK/PS2_DAT, deglitches them, and deframes 11-bit frames with parity, stop-bit and timeout checks.
- Decodes the E0 (extended) and F0 (break) prefixes into tagged key events, which are buffered in a valid/ready FIFO for the CPU/display logic.
- Keeps the legacy data_out "currently held key" output: make code while held, 0 after that key is released.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before a filtered PS2 line changes level (>=2)
TIMEOUT_CYCLES, 100000, clk cycles with no filtered PS2_CLK falling edge before an in-progress frame is aborted (2 ms at 50 MHz)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
PS2_CLK  in  1  raw PS/2 clock from keyboard (asynchronous)
PS2_DAT  in  1  raw PS/2 data from keyboard (asynchronous)
ev_valid  out  1  FIFO non-empty
ev_ready  in  1  consumer accepts head event when ev_valid && ev_ready
ev_code  out  8  head event scan code
ev_break  out  1  head event is a release (F0-prefixed)
ev_ext  out  1  head event is extended (E0-prefixed)
ev_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
data_out  out  8  currently held key make code, 0 when none
parity_err  out  1  one-cycle pulse: frame failed odd parity
frame_err  out  1  one-cycle pulse: bad stop bit or timeout
overflow  out  1  one-cycle pulse: event dropped, FIFO full

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; FIFO empty; prefix flags cleared.
  - All outputs are 0: ev_valid, ev_code, ev_break, ev_ext, ev_count, data_out, parity_err, frame_err, overflow.
  - Filtered line levels reset to 1.
  - A reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-FF synchroniser on each line.
  - Each filter holds its current level until FILTER_LEN consecutive samples disagree with it, then flips.
  - Pulses shorter than FILTER_LEN cycles are invisible to the FSM.
- fall = a 1->0 transition of filtered PS2_CLK (single-cycle strobe). Filtered PS2_DAT is sampled on fall.
- FSM IDLE/DATA/PARITY/STOP, advancing only on fall:
  - IDLE: DAT=0 -> DATA with bit count 0; DAT=1 -> ignored.
  - DATA: shift right, LSB first. After 8 bits -> PARITY.
  - PARITY: perr = XOR(8 data bits, parity bit) == 0 (odd parity required) -> STOP.
  - STOP:
    - DAT=0 -> frame_err pulse.
    - DAT=1 with perr -> parity_err pulse.
    - DAT=1 without perr -> byte_done.
    - In all three cases -> IDLE.
- Timeout:
  - In DATA/PARITY/STOP, a counter is cleared on each fall.
  - When it reaches TIMEOUT_CYCLES: frame_err pulse, frame discarded, -> IDLE.
- Decoder, on byte_done:
  - 0xE0 sets ext_pending; 0xF0 sets brk_pending. Neither byte is ever emitted.
  - Any other byte pushes {ext_pending, brk_pending, byte}, then clears both flags.
  - parity_err and frame_err also clear both flags.
- data_out, updated in the same cycle as the push:
  - Make event -> data_out = code.
  - Break event with code == data_out -> data_out = 0.
  - Break event for any other code -> no change.
  - data_out updates even if the event is dropped on overflow.
- Latency: ev_valid (for an empty FIFO) and data_out update exactly 2 clk cycles after the fall cycle of the stop bit.
- FIFO:
  - First-word fall-through; ev_* reflect the head entry.
  - Pop on ev_valid && ev_ready.
  - Push when full without a pop in the same cycle: event dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Push and pop in the same cycle otherwise: ev_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_code/ev_break/ev_ext are 0 when empty.

Test Plan:
1. rst low for 10 cycles, then high with lines idle at 1 -> all outputs 0, ev_valid 0.
2. Frame 0x15 (parity 0, stop 1) at ~15 kHz -> one event code 0x15, break 0, ext 0; data_out=0x15 two cycles after the stop-bit fall. Then F0 followed by 15 -> one event code 0x15, break 1; data_out=0x00; ev_count=2 with ev_ready held low.
3. E0 75, then E0 F0 75 -> events {0x75, ext 1, break 0} and {0x75, ext 1, break 1}; no E0/F0 events; data_out 0x75 then 0x00.
4. Frame 0x15 with parity bit 1 -> parity_err single pulse, no event, data_out unchanged. Frame with stop bit 0 -> frame_err pulse. Start bit plus 5 data bits then lines held high -> frame_err exactly TIMEOUT_CYCLES after the last fall. A following good 0x1C frame is received correctly.
5. ev_ready low, 9 make frames 0x16..0x1E with FIFO_DEPTH=8 -> ev_count=8, overflow pulses once on 0x1E, data_out=0x1E. Draining with ev_ready high pops 0x16..0x1D in order, then ev_valid 0.
6. 3-cycle low glitches on PS2_CLK while idle, and mid-bit on PS2_DAT, with FILTER_LEN=8 -> no state change, no errors; the subsequent 0x15 frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: oversampled and deglitched lines, 11-bit deframer with
// parity/stop/timeout checks, E0/F0 prefix decoder, event FIFO and held-key register.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DAT,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [7:0]                  ev_code,
  output logic                        ev_break,
  output logic                        ev_ext,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic [7:0]                  data_out,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam logic [7:0] BRK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  // Line conditioning: bit 0 is PS2_CLK, bit 1 is PS2_DAT.
  logic [1:0]    sync1_q, sync2_q, lvl_q;
  logic [FW-1:0] flt_cnt_q [2];
  logic          clk_prev_q;
  logic          fall, dat_f;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      lvl_q      <= '1;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= {PS2_DAT, PS2_CLK};
      sync2_q    <= sync1_q;
      clk_prev_q <= lvl_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == FW'(FILTER_LEN - 1)) begin
          lvl_q[i]     <= sync2_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + FW'(1);
        end
      end
    end
  end

  assign fall  = clk_prev_q & ~lvl_q[0];
  assign dat_f = lvl_q[1];

  // Deframer
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          perr_q, perr_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_hit;
  logic          done_d, perr_pulse_d, ferr_pulse_d;
  logic          done_q, perr_pulse_q, ferr_pulse_q;
  logic [7:0]    byte_q;

  // to_cnt_q holds cycles elapsed since the last fall; the error register adds
  // one more, so the abort fires one count early to land exactly on the limit.
  assign to_hit = (state_q != IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    if (fall)                 to_cnt_d = TW'(1);
    else if (state_q == IDLE) to_cnt_d = '0;
    else                      to_cnt_d = to_cnt_q + TW'(1);
    if (to_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE: if (!dat_f) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {dat_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          perr_d  = ~(^shift_q ^ dat_f);
          state_d = STOP;
        end
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    done_d       = 1'b0;
    perr_pulse_d = 1'b0;
    ferr_pulse_d = 1'b0;
    if (to_hit) begin
      ferr_pulse_d = 1'b1;
    end else if (fall && state_q == STOP) begin
      if (!dat_f)      ferr_pulse_d = 1'b1;
      else if (perr_q) perr_pulse_d = 1'b1;
      else             done_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q       <= 1'b0;
      perr_pulse_q <= 1'b0;
      ferr_pulse_q <= 1'b0;
      byte_q       <= '0;
    end else begin
      done_q       <= done_d;
      perr_pulse_q <= perr_pulse_d;
      ferr_pulse_q <= ferr_pulse_d;
      if (done_d) byte_q <= shift_q;
    end
  end

  // Prefix decoder, held-key register and event FIFO
  logic                ext_pend_q, brk_pend_q;
  logic [7:0]          data_out_q;
  logic [AW:0]         count_q;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                overflow_q;
  event_t              mem_q [FIFO_DEPTH];
  event_t              push_ev, head;
  logic                push, pop, full, do_push;

  assign push    = done_q && (byte_q != EXT_PREFIX) && (byte_q != BRK_PREFIX);
  assign push_ev = '{ext: ext_pend_q, brk: brk_pend_q, code: byte_q};
  assign pop     = ev_valid && ev_ready;
  assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      if (perr_pulse_q || ferr_pulse_q) begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end else if (done_q) begin
        if (byte_q == EXT_PREFIX) begin
          ext_pend_q <= 1'b1;
        end else if (byte_q == BRK_PREFIX) begin
          brk_pend_q <= 1'b1;
        end else begin
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end
      end
      // The held key tracks every decoded event, even one dropped on overflow.
      if (push) begin
        if (!brk_pend_q)              data_out_q <= byte_q;
        else if (byte_q == data_out_q) data_out_q <= '0;
      end
    end
  end

  // NOTE: FIFO storage is not reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_ev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push && full && !pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !pop)      count_q <= count_q + (AW + 1)'(1);
      else if (!do_push && pop) count_q <= count_q - (AW + 1)'(1);
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign ev_valid   = (count_q != '0);
  assign ev_code    = ev_valid ? head.code : '0;
  assign ev_break   = ev_valid ? head.brk  : 1'b0;
  assign ev_ext     = ev_valid ? head.ext  : 1'b0;
  assign ev_count   = count_q;
  assign data_out   = data_out_q;
  assign parity_err = perr_pulse_q;
  assign frame_err  = ferr_pulse_q;
  assign overflow   = overflow_q;
endmodule
